// File: rtl/sha2_pkg.sv
// sha2_pkg: shared types, constants and round functions for the SHA-2 core.
//   sha2_word_t   32-bit working word
//   sha2_state_e  controller states IDLE / ROUND / FINAL
//   K, IV256      round constants and SHA-256 initial hash
//   IV224         SHA-224 initial hash, present only with SHA2_SHA224_EN
//   ch, maj, bsig0, bsig1, ssig0, ssig1   FIPS 180-4 logical functions
package sha2_pkg;

   typedef logic [31:0] sha2_word_t;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} sha2_state_e;

   localparam sha2_word_t K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam sha2_word_t IV256 [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

`ifdef SHA2_SHA224_EN
   localparam sha2_word_t IV224 [0:7] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };
`endif

   function automatic sha2_word_t rotr(input sha2_word_t x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic sha2_word_t ch(input sha2_word_t x, y, z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic sha2_word_t maj(input sha2_word_t x, y, z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic sha2_word_t bsig0(input sha2_word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic sha2_word_t bsig1(input sha2_word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic sha2_word_t ssig0(input sha2_word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic sha2_word_t ssig1(input sha2_word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha2_msg_schedule.sv
// sha2_msg_schedule: 16-word sliding message-schedule window.
//   clk_i, rst_ni  clock, async active-low reset
//   load_i         copy block_i into the window (W0 = block_i[511:480])
//   shift_i        advance one round; the new tail word is W[t+16]
//   block_i        padded 512-bit message block
//   w_o            W[t] for the current round
module sha2_msg_schedule
   import sha2_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [511:0]     block_i,
   output sha2_word_t       w_o
);

   sha2_word_t win_q [0:15];
   sha2_word_t w_next;

   // With win_q[0] = W[t]: W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
   assign w_next = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
   assign w_o    = win_q[0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 16; i++) win_q[i] <= '0;
      end else if (load_i) begin
         for (int i = 0; i < 16; i++) win_q[i] <= block_i[511 - 32*i -: 32];
      end else if (shift_i) begin
         for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
         win_q[15] <= w_next;
      end
   end

endmodule

// File: rtl/sha2_core.sv
// sha2_core: iterative SHA-256 / SHA-224 compression, one round per cycle.
// Optional feature macro: SHA2_SHA224_EN (runtime SHA-224 via mode_i).
//   clk_i, rst_ni    clock, async active-low reset
//   block_i          padded 512-bit block, W0 in the MSBs
//   mode_i           0 = SHA-256, 1 = SHA-224; taken on rst_hash_i
//   enable_hash_i    start a block (only when idle)
//   rst_hash_i       load IV for mode_i, clear digest_valid_o
//   hold_o / idle_o  busy / not busy
//   digest_o         H0..H7, H0 in MSBs; SHA-224 zeroes [31:0]
//   digest_valid_o   digest_o holds the last completed block's result
module sha2_core
   import sha2_pkg::*;
#(
   parameter int BlockWidth  = 512,
   parameter int DigestWidth = 256,
   parameter int Rounds      = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [BlockWidth-1:0]  block_i,
   input  logic                   mode_i,
   input  logic                   enable_hash_i,
   input  logic                   rst_hash_i,
   output logic                   hold_o,
   output logic                   idle_o,
   output logic [DigestWidth-1:0] digest_o,
   output logic                   digest_valid_o
);

   if (BlockWidth != 512) begin : g_bad_block
      $error("sha2_core: BlockWidth must be 512");
   end
   if (Rounds != 64) begin : g_bad_rounds
      $error("sha2_core: Rounds must be 64");
   end
   if (DigestWidth != 256) begin : g_bad_digest
      $error("sha2_core: DigestWidth must be 256");
   end

   sha2_state_e state_q, state_d;
   logic [5:0]  cnt_q;
   sha2_word_t  hv_q [0:7];
   sha2_word_t  wv_q [0:7];
   logic        valid_q;
   logic        mode224_q;
   logic        load_iv, start, do_round, finalize;
   sha2_word_t  w_cur, t1, t2;
   logic [DigestWidth-1:0] dig;

   // ---------------- controller ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      load_iv  = 1'b0;
      start    = 1'b0;
      do_round = 1'b0;
      finalize = 1'b0;
      unique case (state_q)
         IDLE: begin
            // rst_hash_i wins; a simultaneous enable is dropped, not queued
            if (rst_hash_i) begin
               load_iv = 1'b1;
            end else if (enable_hash_i) begin
               start   = 1'b1;
               state_d = ROUND;
            end
         end
         ROUND: begin
            do_round = 1'b1;
            if (cnt_q == 6'(Rounds - 1)) state_d = FINAL;
         end
         FINAL: begin
            finalize = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign hold_o = (state_q != IDLE);
   assign idle_o = ~hold_o;

   // ---------------- message schedule ----------------
   sha2_msg_schedule u_sched (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (start),
      .shift_i (do_round),
      .block_i (block_i),
      .w_o     (w_cur)
   );

   // ---------------- round function ----------------
   always_comb begin
      t1 = wv_q[7] + bsig1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6]) + K[cnt_q] + w_cur;
      t2 = bsig0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);
   end

   // ---------------- mode latch ----------------
`ifdef SHA2_SHA224_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      mode224_q <= 1'b0;
      else if (load_iv) mode224_q <= mode_i;
   end
`else
   logic unused_mode;
   assign unused_mode = mode_i;
   assign mode224_q   = 1'b0;
`endif

   // ---------------- datapath ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 8; i++) begin
            hv_q[i] <= IV256[i];
            wv_q[i] <= '0;
         end
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         if (load_iv) begin
            for (int i = 0; i < 8; i++) begin
`ifdef SHA2_SHA224_EN
               hv_q[i] <= mode_i ? IV224[i] : IV256[i];
`else
               hv_q[i] <= IV256[i];
`endif
            end
            valid_q <= 1'b0;
         end
         if (start) begin
            for (int i = 0; i < 8; i++) wv_q[i] <= hv_q[i];
            cnt_q   <= '0;
            valid_q <= 1'b0;
         end
         if (do_round) begin
            wv_q[0] <= t1 + t2;
            wv_q[1] <= wv_q[0];
            wv_q[2] <= wv_q[1];
            wv_q[3] <= wv_q[2];
            wv_q[4] <= wv_q[3] + t1;
            wv_q[5] <= wv_q[4];
            wv_q[6] <= wv_q[5];
            wv_q[7] <= wv_q[6];
            cnt_q   <= cnt_q + 6'd1;
         end
         if (finalize) begin
            for (int i = 0; i < 8; i++) hv_q[i] <= hv_q[i] + wv_q[i];
            valid_q <= 1'b1;
         end
      end
   end

   // H is only exposed once a block has finished, so reset, IV loads and
   // in-flight hashes all read as zero on digest_o.
   always_comb begin
      dig = '0;
      for (int i = 0; i < 8; i++) dig[255 - 32*i -: 32] = hv_q[i];
      if (mode224_q) dig[31:0] = '0;
      digest_o = valid_q ? dig : '0;
   end

   assign digest_valid_o = valid_q;

endmodule

// File: tb/tb_sha2_core.sv
// tb_sha2_core: directed self-checking bench for sha2_core (NIST vectors).
module tb_sha2_core;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic [511:0] block_i;
   logic         mode_i;
   logic         enable_hash_i;
   logic         rst_hash_i;
   logic         hold_o, idle_o, digest_valid_o;
   logic [255:0] digest_o;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_TWO1  = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_TWO2  = {448'h0, 64'h1c0};

   localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] D_224   = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};

   sha2_core dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .block_i        (block_i),
      .mode_i         (mode_i),
      .enable_hash_i  (enable_hash_i),
      .rst_hash_i     (rst_hash_i),
      .hold_o         (hold_o),
      .idle_o         (idle_o),
      .digest_o       (digest_o),
      .digest_valid_o (digest_valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_rst_hash(input logic m);
      mode_i     = m;
      rst_hash_i = 1'b1;
      @(posedge clk_i); #1;
      rst_hash_i = 1'b0;
      mode_i     = 1'b0;
   endtask

   // Accept at edge N, check busy/not-valid after N+64 and done after N+65.
   task automatic run_block(input string tag, input logic [511:0] blk);
      block_i       = blk;
      enable_hash_i = 1'b1;
      @(posedge clk_i); #1;
      enable_hash_i = 1'b0;
      block_i       = ~blk;
      repeat (64) @(posedge clk_i);
      #1;
      chk({tag, "_hold_n64"},  256'(hold_o), 256'(1));
      chk({tag, "_valid_n64"}, 256'(digest_valid_o), 256'(0));
      @(posedge clk_i); #1;
      chk({tag, "_valid_n65"}, 256'(digest_valid_o), 256'(1));
      chk({tag, "_idle_n65"},  256'(idle_o), 256'(1));
   endtask

   initial begin
      rst_ni = 1'b0; block_i = '0; mode_i = 1'b0;
      enable_hash_i = 1'b0; rst_hash_i = 1'b0;
      #12;
      chk("rst_hold",   256'(hold_o), 256'(0));
      chk("rst_idle",   256'(idle_o), 256'(1));
      chk("rst_valid",  256'(digest_valid_o), 256'(0));
      chk("rst_digest", digest_o, 256'h0);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // 1: "abc" straight after reset, IV256 by default
      run_block("abc", BLK_ABC);
      chk("abc_digest", digest_o, D_ABC);

      // 2: empty message
      pulse_rst_hash(1'b0);
      chk("rsthash_clears_valid", 256'(digest_valid_o), 256'(0));
      run_block("empty", BLK_EMPTY);
      chk("empty_digest", digest_o, D_EMPTY);

      // 3: two chained blocks
      pulse_rst_hash(1'b0);
      run_block("two1", BLK_TWO1);
      run_block("two2", BLK_TWO2);
      chk("two_digest", digest_o, D_TWO);

      // 4: mode_i=1 ("abc"); SHA-256 result when the feature is compiled out
      pulse_rst_hash(1'b1);
      run_block("m224", BLK_ABC);
`ifdef SHA2_SHA224_EN
      chk("sha224_digest", digest_o, D_224);
`else
      chk("mode_ignored_digest", digest_o, D_ABC);
`endif

      // 5: enable and rst_hash during rounds are ignored
      pulse_rst_hash(1'b0);
      block_i = BLK_ABC; enable_hash_i = 1'b1;
      @(posedge clk_i); #1;
      enable_hash_i = 1'b0;
      repeat (9) @(posedge clk_i);
      #1;
      block_i = BLK_EMPTY; enable_hash_i = 1'b1;
      @(posedge clk_i); #1;
      enable_hash_i = 1'b0;
      repeat (9) @(posedge clk_i);
      #1;
      rst_hash_i = 1'b1; mode_i = 1'b1;
      @(posedge clk_i); #1;
      rst_hash_i = 1'b0; mode_i = 1'b0;
      for (int i = 0; i < 80 && !digest_valid_o; i++) begin
         @(posedge clk_i); #1;
      end
      chk("ign_valid",  256'(digest_valid_o), 256'(1));
      chk("ign_digest", digest_o, D_ABC);
      @(posedge clk_i); #1;
      chk("ign_no_restart", 256'(hold_o), 256'(0));

      // enable + rst_hash together in IDLE: IV load only, no hash
      block_i = BLK_EMPTY; enable_hash_i = 1'b1; rst_hash_i = 1'b1;
      @(posedge clk_i); #1;
      enable_hash_i = 1'b0; rst_hash_i = 1'b0;
      chk("both_hold",  256'(hold_o), 256'(0));
      chk("both_valid", 256'(digest_valid_o), 256'(0));
      @(posedge clk_i); #1;
      chk("both_hold2", 256'(hold_o), 256'(0));
      run_block("after_both", BLK_ABC);
      chk("after_both_digest", digest_o, D_ABC);

      // 6: asynchronous abort mid-hash
      pulse_rst_hash(1'b0);
      block_i = BLK_EMPTY; enable_hash_i = 1'b1;
      @(posedge clk_i); #1;
      enable_hash_i = 1'b0;
      repeat (30) @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("abort_hold",   256'(hold_o), 256'(0));
      chk("abort_valid",  256'(digest_valid_o), 256'(0));
      chk("abort_digest", digest_o, 256'h0);
      #2;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("abort_stays_idle", 256'(hold_o), 256'(0));
      pulse_rst_hash(1'b0);
      run_block("post_abort", BLK_ABC);
      chk("post_abort_digest", digest_o, D_ABC);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
